// File: rtl/dsp_ram_scheduler.sv
// Time-slot scheduler for the shared ARAM read port: voices, echo reader and
// directory fetcher each own fixed steps of a 64-step sample frame.
module dsp_ram_scheduler #(
    parameter int N_VOICES       = 8,
    parameter int VOICE_SLOT_LEN = 4,
    parameter int ECHO_FIRST     = 33,
    parameter int DIR_FIRST      = 41
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable_i,
    output logic [5:0]                    step_o,
    output logic                          sample_strobe_o,
    output logic [N_VOICES-1:0]           voice_trigger_o,
    input  logic [N_VOICES-1:0]           voice_req_i,
    input  logic [16*N_VOICES-1:0]        voice_addr_i,
    output logic [N_VOICES-1:0]           voice_grant_o,
    input  logic                          echo_req_i,
    input  logic [15:0]                   echo_addr_i,
    output logic                          echo_grant_o,
    input  logic [7:0]                    dir_base_i,
    input  logic [8*N_VOICES-1:0]         srcn_flat_i,
    output logic [$clog2(N_VOICES)-1:0]   dir_voice_o,
    output logic [15:0]                   ram_address_o,
    input  logic [7:0]                    ram_data_i,
    output logic                          rd_valid_o,
    output logic [3:0]                    rd_owner_o,
    output logic [1:0]                    rd_dir_index_o,
    output logic [7:0]                    rd_data_o
);

    localparam int         VW        = $clog2(N_VOICES);
    localparam logic [5:0] VOICE_END = 6'(N_VOICES * VOICE_SLOT_LEN);
    localparam logic [5:0] SLOT_LEN  = 6'(VOICE_SLOT_LEN);
    localparam logic [5:0] ECHO_LO   = 6'(ECHO_FIRST);
    localparam logic [5:0] ECHO_HI   = 6'(ECHO_FIRST + 8);
    localparam logic [5:0] DIR_LO    = 6'(DIR_FIRST);
    localparam logic [5:0] DIR_HI    = 6'(DIR_FIRST + 4);

    logic [5:0]    step_q, step_d;
    logic [VW-1:0] dir_voice_q, dir_voice_d;
    logic          rd_valid_q;
    logic [3:0]    rd_owner_q;
    logic [1:0]    rd_dir_index_q;
    logic [7:0]    rd_data_q;

    logic          active, in_voice, in_echo, in_dir, first_step;
    logic          dir_grant, granted;
    logic [5:0]    slot_idx, dir_off;
    logic [VW-1:0] vidx;
    logic [1:0]    dir_k;
    logic [3:0]    owner;
    logic [7:0]    srcn_sel;
    logic [15:0]   voice_addr_sel;

    always_comb begin
        active     = enable_i && !reset;
        in_voice   = step_q < VOICE_END;
        in_echo    = (step_q >= ECHO_LO) && (step_q < ECHO_HI);
        in_dir     = (step_q >= DIR_LO) && (step_q < DIR_HI);
        slot_idx   = step_q / SLOT_LEN;
        vidx       = slot_idx[VW-1:0];
        first_step = (step_q % SLOT_LEN) == 6'd0;
        dir_off    = step_q - DIR_LO;
        dir_k      = dir_off[1:0];
        owner      = in_voice ? 4'(vidx) : (in_echo ? 4'd8 : 4'd9);
    end

    // Slot ownership is static, so each voice only has to recognise its own window.
    for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
        logic own;
        assign own                = active && in_voice && (vidx == VW'(v));
        assign voice_grant_o[v]   = own && voice_req_i[v];
        assign voice_trigger_o[v] = own && first_step;
    end

    assign echo_grant_o    = active && in_echo && echo_req_i;
    assign dir_grant       = active && in_dir;
    assign granted         = (|voice_grant_o) || echo_grant_o || dir_grant;
    assign sample_strobe_o = active && (step_q == 6'd63);

    assign voice_addr_sel = voice_addr_i[{vidx, 4'b0000} +: 16];
    assign srcn_sel       = srcn_flat_i[{dir_voice_q, 3'b000} +: 8];

    always_comb begin
        ram_address_o = 16'h0000;
        if (|voice_grant_o)
            ram_address_o = voice_addr_sel;
        else if (echo_grant_o)
            ram_address_o = echo_addr_i;
        else if (dir_grant)
            // Directory entries are 4 bytes; the sum wraps at 16 bits.
            ram_address_o = {dir_base_i, 8'h00} + {6'd0, srcn_sel, 2'b00} + {14'd0, dir_k};
    end

    always_comb begin
        step_d      = step_q + 6'd1;
        dir_voice_d = (step_q == 6'd63) ? dir_voice_q + VW'(1) : dir_voice_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q         <= 6'd63;
            dir_voice_q    <= '0;
            rd_valid_q     <= 1'b0;
            rd_owner_q     <= 4'd0;
            rd_dir_index_q <= 2'd0;
            rd_data_q      <= 8'h00;
        end else if (enable_i) begin
            step_q      <= step_d;
            dir_voice_q <= dir_voice_d;
            rd_valid_q  <= granted;
            if (granted) begin
                rd_data_q      <= ram_data_i;
                rd_owner_q     <= owner;
                rd_dir_index_q <= in_dir ? dir_k : 2'd0;
            end
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign step_o         = step_q;
    assign dir_voice_o    = dir_voice_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_owner_o     = rd_owner_q;
    assign rd_dir_index_o = rd_dir_index_q;
    assign rd_data_o      = rd_data_q;

endmodule

// File: tb/tb_dsp_ram_scheduler.sv
// Directed bench for dsp_ram_scheduler: a frame-level model checked every
// cycle, plus literal expectations at the key steps.
module tb_dsp_ram_scheduler;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [5:0]   step_o;
    logic         sample_strobe;
    logic [7:0]   voice_trigger;
    logic [7:0]   voice_req = '0;
    logic [127:0] voice_addr = '0;
    logic [7:0]   voice_grant;
    logic         echo_req = 1'b0;
    logic [15:0]  echo_addr = '0;
    logic         echo_grant;
    logic [7:0]   dir_base = '0;
    logic [63:0]  srcn_flat = '0;
    logic [2:0]   dir_voice;
    logic [15:0]  ram_address;
    logic [7:0]   ram_data = '0;
    logic         rd_valid;
    logic [3:0]   rd_owner;
    logic [1:0]   rd_dir_index;
    logic [7:0]   rd_data;

    int errors = 0;
    int checks = 0;

    dsp_ram_scheduler dut (
        .clock(clock), .reset(reset), .enable_i(enable),
        .step_o(step_o), .sample_strobe_o(sample_strobe),
        .voice_trigger_o(voice_trigger), .voice_req_i(voice_req),
        .voice_addr_i(voice_addr), .voice_grant_o(voice_grant),
        .echo_req_i(echo_req), .echo_addr_i(echo_addr), .echo_grant_o(echo_grant),
        .dir_base_i(dir_base), .srcn_flat_i(srcn_flat), .dir_voice_o(dir_voice),
        .ram_address_o(ram_address), .ram_data_i(ram_data),
        .rd_valid_o(rd_valid), .rd_owner_o(rd_owner),
        .rd_dir_index_o(rd_dir_index), .rd_data_o(rd_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: state is the step number, directory voice and last readback.
    int         m_step = 63, m_dir = 0, m_owner = 0, m_idx = 0;
    logic       m_rdv = 1'b0;
    logic [7:0] m_data = '0;

    initial begin
        logic       en, e_eg, e_strobe, gnt;
        logic [7:0] e_vg, e_trig;
        logic [15:0] e_addr;
        int         v, k, owner;
        @(posedge clock);
        forever begin
            @(negedge clock);
            en = enable && !reset;
            e_vg = '0; e_eg = 1'b0; e_trig = '0; e_addr = '0; e_strobe = 1'b0;
            gnt = 1'b0; owner = 0; k = 0;
            if (en) begin
                e_strobe = (m_step == 63);
                if (m_step < 32) begin
                    v = m_step / 4;
                    if (m_step % 4 == 0) e_trig[v] = 1'b1;
                    if (voice_req[v]) begin
                        e_vg[v] = 1'b1; e_addr = voice_addr[v*16 +: 16]; gnt = 1'b1; owner = v;
                    end
                end else if (m_step >= 33 && m_step <= 40) begin
                    if (echo_req) begin
                        e_eg = 1'b1; e_addr = echo_addr; gnt = 1'b1; owner = 8;
                    end
                end else if (m_step >= 41 && m_step <= 44) begin
                    k = m_step - 41;
                    e_addr = 16'((dir_base * 256 + srcn_flat[m_dir*8 +: 8] * 4 + k) % 65536);
                    gnt = 1'b1; owner = 9;
                end
            end
            chk("step", step_o, m_step);
            chk("dir_voice", dir_voice, m_dir);
            chk("sample_strobe", sample_strobe, e_strobe);
            chk("voice_trigger", voice_trigger, e_trig);
            chk("voice_grant", voice_grant, e_vg);
            chk("echo_grant", echo_grant, e_eg);
            chk("ram_address", ram_address, e_addr);
            chk("rd_valid", rd_valid, m_rdv);
            chk("rd_owner", rd_owner, m_owner);
            chk("rd_data", rd_data, m_data);
            if (m_owner == 9) chk("rd_dir_index", rd_dir_index, m_idx);
            if (reset) begin
                m_step = 63; m_dir = 0; m_rdv = 1'b0; m_owner = 0; m_idx = 0; m_data = '0;
            end else if (enable) begin
                if (m_step == 63) m_dir = (m_dir + 1) % 8;
                m_step = (m_step + 1) % 64;
                m_rdv = gnt;
                if (gnt) begin
                    m_data = ram_data; m_owner = owner; m_idx = k;
                end
            end else begin
                m_rdv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        ram_data = 8'($urandom);
    endtask

    task automatic goto_step(input int n);
        int i = 0;
        while (step_o != 6'(n) && i < 200) begin
            tick();
            i++;
        end
        if (step_o != 6'(n)) begin
            errors++; checks++;
            $display("FAIL goto_step: got %0d expected %0d", step_o, n);
        end
    endtask

    initial begin
        int i;
        tick(); tick();
        #2;
        chk("lit_reset_step", step_o, 63);
        chk("lit_reset_rd_valid", rd_valid, 0);
        chk("lit_reset_dir_voice", dir_voice, 0);
        chk("lit_reset_rd_owner", rd_owner, 0);
        chk("lit_reset_rd_dir_index", rd_dir_index, 0);
        chk("lit_reset_rd_data", rd_data, 0);
        chk("lit_reset_ram_address", ram_address, 0);
        chk("lit_reset_strobe", sample_strobe, 0);
        reset = 1'b0; enable = 1'b1;

        tick(); #2;
        chk("lit_first_step", step_o, 0);
        chk("lit_trigger_step0", voice_trigger, 8'h01);

        // Request from voice 5 outside its window is ignored.
        goto_step(3);
        voice_req = 8'h20; #2;
        chk("lit_oow_grant", voice_grant, 0);
        chk("lit_oow_addr", ram_address, 0);
        tick(); #2;
        chk("lit_oow_no_rd_valid", rd_valid, 0);
        voice_req = '0;

        goto_step(12);
        voice_req = 8'h08; voice_addr[63:48] = 16'h1234; ram_data = 8'hA5; #2;
        chk("lit_v3_grant", voice_grant, 8'h08);
        chk("lit_v3_addr", ram_address, 16'h1234);
        tick(); #2;
        chk("lit_v3_rd_valid", rd_valid, 1);
        chk("lit_v3_rd_owner", rd_owner, 3);
        chk("lit_v3_rd_data", rd_data, 8'hA5);
        goto_step(16);
        voice_req = '0;

        goto_step(28); #2;
        chk("lit_trigger_step28", voice_trigger, 8'h80);

        goto_step(33);
        echo_req = 1'b1; echo_addr = 16'hBEEF;
        tick(); #2;
        chk("lit_echo_grant", echo_grant, 1);
        chk("lit_echo_addr", ram_address, 16'hBEEF);
        goto_step(41);
        echo_req = 1'b0;

        goto_step(63); #2;
        chk("lit_strobe_63", sample_strobe, 1);

        // Directory fetch for voice 0: 0x0200 + 0x05*4 + k.
        dir_base = 8'h02;
        srcn_flat = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h05};
        i = 0;
        while (!(step_o == 6'd41 && dir_voice == 3'd0) && i < 1200) begin
            tick(); i++;
        end
        chk("lit_dir_reach", {step_o, 3'(dir_voice)}, {6'd41, 3'd0});
        for (int k = 0; k < 4; k++) begin
            ram_data = 8'h30 + 8'(k); #2;
            chk("lit_dir_addr", ram_address, 16'h0214 + 16'(k));
            tick(); #2;
            chk("lit_dir_rd_valid", rd_valid, 1);
            chk("lit_dir_rd_owner", rd_owner, 9);
            chk("lit_dir_rd_index", rd_dir_index, k);
            chk("lit_dir_rd_data", rd_data, 8'h30 + 8'(k));
        end
        goto_step(0); #2;
        chk("lit_dir_voice_next", dir_voice, 1);

        // 0xFF00 + 0x3FC + 3 = 0x102FF, wraps to 0x02FF.
        dir_base = 8'hFF; srcn_flat = {8{8'hFF}};
        goto_step(44); #2;
        chk("lit_dir_wrap", ram_address, 16'h02FF);

        goto_step(20);
        voice_req = 8'h20; enable = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick(); #2;
            chk("lit_hold_step", step_o, 20);
            chk("lit_hold_grant", voice_grant, 0);
            chk("lit_hold_rd_valid", rd_valid, 0);
        end
        enable = 1'b1; voice_req = '0;

        goto_step(33);
        echo_req = 1'b1; echo_addr = 16'h4321;
        tick(); #2;
        chk("lit_pre_reset_step", step_o, 34);
        reset = 1'b1;
        tick(); #2;
        chk("lit_mid_reset_step", step_o, 63);
        chk("lit_mid_reset_rd_valid", rd_valid, 0);
        reset = 1'b0; echo_req = 1'b0;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
